// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave front-end.
// Parity option: SPI_SLAVE_PARITY_EN.
package spi_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CMD_W_DEF  = 2;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        END
    } state_t;

endpackage

// File: rtl/spi_slave_param_if.sv
// Serial pins plus RAM-side rx/tx bundle of the SPI slave.
// Parity option: SPI_SLAVE_PARITY_EN.
interface spi_slave_param_if #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
);
    localparam int RX_W = CMD_W + DATA_W;

    logic              ss_n;
    logic              MOSI;
    logic              MISO;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic [RX_W-1:0]   rx_data;
    logic              parity_err;

    modport slave (
        input  ss_n, MOSI, tx_valid, tx_data,
        output MISO, rx_valid, rx_data, parity_err
    );

    modport master (
        output ss_n, MOSI, tx_valid, tx_data,
        input  MISO, rx_valid, rx_data, parity_err
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// MISO path: load a read word, shift it out MSB first.
// Parity option: SPI_SLAVE_PARITY_EN (not used here).
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              clr,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done
);
    localparam int RW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh;
    logic [RW-1:0]     rem;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            sh  <= '0;
            rem <= '0;
        end else if (load) begin
            sh  <= data;
            rem <= RW'(DATA_W);
        end else if (shift && rem != '0) begin
            sh  <= sh << 1;
            rem <= rem - 1'b1;
        end
    end

    // rem counts bits still on the wire, so MISO idles low once empty
    assign miso = (rem != '0) && sh[DATA_W-1];
    assign done = shift && (rem == RW'(1));

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: CMD+DATA deserialiser and read-data return.
// Parity option: define SPI_SLAVE_PARITY_EN.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CMD_W  = CMD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_param_if.slave bus
);
    localparam int RX_W = CMD_W + DATA_W;
`ifdef SPI_SLAVE_PARITY_EN
    localparam int LAST = RX_W + 1;
    localparam int SH_W = RX_W;
`else
    localparam int LAST = RX_W;
    localparam int SH_W = RX_W - 1;
`endif
    localparam int CNT_W = $clog2(LAST + 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] RX_C   = CNT_W'(RX_W);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [SH_W-1:0]  rx_sh;
    logic [RX_W-1:0]  rx_word, rx_data_q;
    logic             rx_valid_q, rd_addr_ok, par_ok;
    logic             bit_in, frm_end, rx_upd, set_ok, clr_ok;
    logic             tx_load, tx_shift, tx_clr, tx_done, miso;

    // Parity build checks the extra bit; otherwise the last bit comes live
`ifdef SPI_SLAVE_PARITY_EN
    assign rx_word = rx_sh;
    assign par_ok  = (bus.MOSI == ^rx_sh);
`else
    assign rx_word = {rx_sh, bus.MOSI};
    assign par_ok  = 1'b1;
`endif

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign rx_upd  = frm_end && par_ok;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_in   = 1'b0;
        frm_end  = 1'b0;
        set_ok   = 1'b0;
        clr_ok   = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        tx_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!bus.ss_n) state_n = CHK_CMD;
            end
            CHK_CMD: begin
                bit_in = 1'b1;
                cnt_n  = CNT_W'(1);
                if (!bus.MOSI)       state_n = WRITE;
                else if (rd_addr_ok) state_n = READ_DATA;
                else                 state_n = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                bit_in = (cnt < RX_C);
                cnt_n  = cnt_inc;
                if (cnt_inc == LAST_C) begin
                    frm_end = 1'b1;
                    if (!par_ok) begin
                        state_n = END;
                    end else if (state == READ_DATA) begin
                        state_n = TX_WAIT;
                    end else begin
                        set_ok  = (state == READ_ADD);
                        state_n = END;
                    end
                end
            end
            TX_WAIT: begin
                if (bus.tx_valid) begin
                    tx_load = 1'b1;
                    state_n = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                tx_shift = 1'b1;
                if (tx_done) begin
                    clr_ok  = 1'b1;
                    state_n = END;
                end
            end
            END: ;
            default: state_n = IDLE;
        endcase
        // Deselect mid-frame overrides everything, including a last bit
        if (bus.ss_n && state != IDLE) begin
            state_n  = IDLE;
            cnt_n    = '0;
            bit_in   = 1'b0;
            frm_end  = 1'b0;
            set_ok   = 1'b0;
            clr_ok   = 1'b0;
            tx_load  = 1'b0;
            tx_shift = 1'b0;
            tx_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_addr_ok <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            rx_valid_q <= rx_upd;
            if (bit_in) rx_sh     <= {rx_sh[SH_W-2:0], bus.MOSI};
            if (rx_upd) rx_data_q <= rx_word;
            if (set_ok)      rd_addr_ok <= 1'b1;
            else if (clr_ok) rd_addr_ok <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk) begin
        if (!rst) perr_q <= 1'b0;
        else      perr_q <= frm_end && !par_ok;
    end
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .shift (tx_shift),
        .clr   (tx_clr),
        .data  (bus.tx_data),
        .miso  (miso),
        .done  (tx_done)
    );

    assign bus.MISO     = miso;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised bench for spi_slave_param against a frame-level model.
// Parity option: SPI_SLAVE_PARITY_EN.
module tb_spi_slave_param;
    import spi_pkg::*;

    localparam int DATA_W = 8;
    localparam int CMD_W  = 2;
    localparam int RX_W   = CMD_W + DATA_W;
`ifdef SPI_SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = RX_W + PAR_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(DATA_W), .CMD_W(CMD_W)) bus_if ();

    spi_slave_param #(.DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // model: address-phase flag and last delivered frame
    logic            ok_m;
    logic [RX_W-1:0] rx_m;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [RX_W-1:0] f, input int abort_at,
                             input bit bad_par, input int tx_delay,
                             input logic [DATA_W-1:0] tbyte,
                             input bit tx_abort, input int rst_at);
        logic expect_tx;
        logic good;
        bus_if.ss_n = 1'b0;
        bus_if.MOSI = 1'($urandom);
        tick();
        for (int i = 0; i < NBITS; i++) begin
            bus_if.MOSI = (i < RX_W) ? f[RX_W-1-i] : (^f ^ bad_par);
            if (i == abort_at) begin
                bus_if.ss_n = 1'b1;
                tick();
                chk("abort_vld", 32'(bus_if.rx_valid), 0);
                chk("abort_data", 32'(bus_if.rx_data), 32'(rx_m));
                chk("abort_perr", 32'(bus_if.parity_err), 0);
                tick();
                chk("abort_miso", 32'(bus_if.MISO), 0);
                return;
            end
            tick();
            if (i < NBITS - 1) chk("early_vld", 32'(bus_if.rx_valid), 0);
        end
        good = !bad_par;
        if (good) rx_m = f;
        chk("rx_valid", 32'(bus_if.rx_valid), 32'(good));
        chk("parity_err", 32'(bus_if.parity_err), 32'(!good));
        chk("rx_data", 32'(bus_if.rx_data), 32'(rx_m));
        expect_tx = good && f[RX_W-1] && ok_m;
        if (good && f[RX_W-1] && !ok_m) ok_m = 1'b1;
        if (tx_abort) begin
            bus_if.ss_n = 1'b1;
            tick();
            chk("txab_vld", 32'(bus_if.rx_valid), 0);
            chk("txab_miso", 32'(bus_if.MISO), 0);
            tick();
            return;
        end
        for (int d = 0; d < tx_delay; d++) begin
            tick();
            chk("wait_miso", 32'(bus_if.MISO), 0);
            chk("pulse_vld", 32'(bus_if.rx_valid), 0);
        end
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = tbyte;
        tick();
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = DATA_W'($urandom);
        for (int b = DATA_W - 1; b >= 0; b--) begin
            if (b == rst_at) begin
                rst = 1'b0;
                bus_if.ss_n = 1'b1;
                tick();
                chk("rst_miso", 32'(bus_if.MISO), 0);
                chk("rst_vld", 32'(bus_if.rx_valid), 0);
                chk("rst_data", 32'(bus_if.rx_data), 0);
                rst  = 1'b1;
                ok_m = 1'b0;
                rx_m = '0;
                tick();
                return;
            end
            chk("miso_bit", 32'(bus_if.MISO), expect_tx ? 32'(tbyte[b]) : 0);
            bus_if.MOSI = 1'($urandom);
            tick();
        end
        chk("miso_end", 32'(bus_if.MISO), 0);
        if (expect_tx) ok_m = 1'b0;
        bus_if.ss_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [RX_W-1:0] f;
        int ab;
        bit bp;
        rst             = 1'b0;
        bus_if.ss_n     = 1'b1;
        bus_if.MOSI     = 1'b0;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = '0;
        ok_m            = 1'b0;
        rx_m            = '0;
        tick();
        tick();
        chk("rst_miso", 32'(bus_if.MISO), 0);
        chk("rst_vld", 32'(bus_if.rx_valid), 0);
        chk("rst_data", 32'(bus_if.rx_data), 0);
        chk("rst_perr", 32'(bus_if.parity_err), 0);
        rst = 1'b1;
        tick();

        // plain write frame, then an abort after 6 bits keeps it
        run_frame({WR_ADDR, 8'hA5}, -1, 1'b0, 2, 8'h5A, 1'b0, -1);
        run_frame({RD_DATA, 8'h3C}, 6, 1'b0, 1, 8'h00, 1'b0, -1);
        // address then data read with a late tx_valid
        run_frame({RD_ADDR, 8'h03}, -1, 1'b0, 2, 8'hFF, 1'b0, -1);
        run_frame({RD_DATA, 8'h77}, -1, 1'b0, 3, 8'hC3, 1'b0, -1);
        // two address frames: the second is routed as a data read
        run_frame({RD_ADDR, 8'h10}, -1, 1'b0, 1, 8'h11, 1'b0, -1);
        run_frame({RD_ADDR, 8'h20}, -1, 1'b0, 1, 8'h96, 1'b0, -1);
        // deselect on the last bit, and during TX_WAIT
        run_frame({WR_DATA, 8'hEE}, NBITS - 1, 1'b0, 1, 8'h00, 1'b0, -1);
        run_frame({RD_ADDR, 8'h40}, -1, 1'b0, 1, 8'h00, 1'b0, -1);
        run_frame({RD_DATA, 8'h41}, -1, 1'b0, 1, 8'h00, 1'b1, -1);
        run_frame({RD_DATA, 8'h42}, -1, 1'b0, 2, 8'h81, 1'b0, -1);
        // reset while shifting, then a read goes to address phase
        run_frame({RD_ADDR, 8'h50}, -1, 1'b0, 1, 8'h00, 1'b0, -1);
        run_frame({RD_DATA, 8'h51}, -1, 1'b0, 1, 8'hA5, 1'b0, 4);
        run_frame({RD_DATA, 8'h52}, -1, 1'b0, 1, 8'hA5, 1'b0, -1);
`ifdef SPI_SLAVE_PARITY_EN
        run_frame(10'h1F0, -1, 1'b1, 1, 8'h00, 1'b0, -1);
        run_frame(10'h1F0, -1, 1'b0, 1, 8'h00, 1'b0, -1);
`endif

        repeat (120) begin
            f  = RX_W'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NBITS - 1)) : -1;
            bp = (PAR_BITS != 0) && ($urandom_range(0, 3) == 0);
            run_frame(f, ab, bp, int'($urandom_range(1, 4)),
                      DATA_W'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
